// File: rtl/modport_alu_if.sv
// Bus bundle for modport_alu: operands/command from the driver side,
// registered result and flags back from the ALU.
interface modport_alu_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [3:0]       cmd;
   logic             ce;
   logic [1:0]       inp_valid;
   logic             mode;
   logic             cin;
   logic [WIDTH+1:0] res;
   logic             oflow;
   logic             cout;
   logic             g;
   logic             l;
   logic             e;
   logic             err;

   modport master (
      output opa, opb, cmd, ce, inp_valid, mode, cin,
      input  res, oflow, cout, g, l, e, err
   );

   modport slave (
      input  opa, opb, cmd, ce, inp_valid, mode, cin,
      output res, oflow, cout, g, l, e, err
   );
endinterface

// File: rtl/modport_alu.sv
// Registered two-operand ALU with arithmetic/logical command sets,
// per-operand valid qualification and one-cycle output latency.
module modport_alu #(
   parameter int unsigned WIDTH = 8
) (
   input logic          clk,
   input logic          reset,
   modport_alu_if.slave bus
);
   localparam int unsigned SW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      A_ADD     = 4'd0,
      A_SUB     = 4'd1,
      A_ADD_CIN = 4'd2,
      A_SUB_CIN = 4'd3,
      A_INC_A   = 4'd4,
      A_DEC_A   = 4'd5,
      A_INC_B   = 4'd6,
      A_DEC_B   = 4'd7,
      A_CMP     = 4'd8
   } arith_cmd_e;

   typedef enum logic [3:0] {
      L_AND  = 4'd0,
      L_NAND = 4'd1,
      L_OR   = 4'd2,
      L_NOR  = 4'd3,
      L_XOR  = 4'd4,
      L_XNOR = 4'd5,
      L_NOTA = 4'd6,
      L_NOTB = 4'd7,
      L_SHRA = 4'd8,
      L_SHLA = 4'd9,
      L_SHRB = 4'd10,
      L_SHLB = 4'd11,
      L_ROL  = 4'd12,
      L_ROR  = 4'd13
   } logic_cmd_e;

   logic [WIDTH+1:0] res_q, res_d;
   logic             oflow_q, oflow_d;
   logic             cout_q, cout_d;
   logic             g_q, g_d;
   logic             l_q, l_d;
   logic             e_q, e_d;
   logic             err_q, err_d;

   logic [WIDTH:0]     ext_a, ext_b, ext_cin, wide;
   logic [WIDTH-1:0]   lres;
   logic [2*WIDTH-1:0] rot_l, rot_r;
   logic [SW-1:0]      sh;
   logic               rot_hi;
   logic               need_a, need_b, cmd_ok, carry_op, borrow_op, cmp_op;

   always_comb begin
      res_d     = '0;
      oflow_d   = 1'b0;
      cout_d    = 1'b0;
      g_d       = 1'b0;
      l_d       = 1'b0;
      e_d       = 1'b0;
      err_d     = 1'b0;
      need_a    = 1'b0;
      need_b    = 1'b0;
      cmd_ok    = 1'b1;
      carry_op  = 1'b0;
      borrow_op = 1'b0;
      cmp_op    = 1'b0;
      wide      = '0;
      lres      = '0;

      ext_a   = {1'b0, bus.opa};
      ext_b   = {1'b0, bus.opb};
      ext_cin = {{WIDTH{1'b0}}, bus.cin};
      sh      = bus.opb[SW-1:0];
      rot_l   = {bus.opa, bus.opa} << sh;
      rot_r   = {bus.opa, bus.opa} >> sh;
      rot_hi  = (bus.opb >> SW) != '0;

      if (bus.mode) begin
         case (arith_cmd_e'(bus.cmd))
            A_ADD:     begin need_a = 1'b1; need_b = 1'b1; carry_op  = 1'b1; wide = ext_a + ext_b; end
            A_SUB:     begin need_a = 1'b1; need_b = 1'b1; borrow_op = 1'b1; wide = ext_a - ext_b; end
            A_ADD_CIN: begin need_a = 1'b1; need_b = 1'b1; carry_op  = 1'b1; wide = ext_a + ext_b + ext_cin; end
            A_SUB_CIN: begin need_a = 1'b1; need_b = 1'b1; borrow_op = 1'b1; wide = ext_a - ext_b - ext_cin; end
            A_INC_A:   begin need_a = 1'b1; carry_op  = 1'b1; wide = ext_a + 1'b1; end
            A_DEC_A:   begin need_a = 1'b1; borrow_op = 1'b1; wide = ext_a - 1'b1; end
            A_INC_B:   begin need_b = 1'b1; carry_op  = 1'b1; wide = ext_b + 1'b1; end
            A_DEC_B:   begin need_b = 1'b1; borrow_op = 1'b1; wide = ext_b - 1'b1; end
            A_CMP:     begin need_a = 1'b1; need_b = 1'b1; cmp_op = 1'b1; end
            default:   cmd_ok = 1'b0;
         endcase
         // Bit WIDTH of the extended result is the carry for adds and the borrow for subtracts.
         if (carry_op) begin
            res_d  = {1'b0, wide};
            cout_d = wide[WIDTH];
         end
         if (borrow_op) begin
            res_d   = {2'b00, wide[WIDTH-1:0]};
            oflow_d = wide[WIDTH];
         end
         if (cmp_op) begin
            g_d = bus.opa > bus.opb;
            l_d = bus.opa < bus.opb;
            e_d = bus.opa == bus.opb;
         end
      end else begin
         case (logic_cmd_e'(bus.cmd))
            L_AND:   begin need_a = 1'b1; need_b = 1'b1; lres = bus.opa & bus.opb; end
            L_NAND:  begin need_a = 1'b1; need_b = 1'b1; lres = ~(bus.opa & bus.opb); end
            L_OR:    begin need_a = 1'b1; need_b = 1'b1; lres = bus.opa | bus.opb; end
            L_NOR:   begin need_a = 1'b1; need_b = 1'b1; lres = ~(bus.opa | bus.opb); end
            L_XOR:   begin need_a = 1'b1; need_b = 1'b1; lres = bus.opa ^ bus.opb; end
            L_XNOR:  begin need_a = 1'b1; need_b = 1'b1; lres = ~(bus.opa ^ bus.opb); end
            L_NOTA:  begin need_a = 1'b1; lres = ~bus.opa; end
            L_NOTB:  begin need_b = 1'b1; lres = ~bus.opb; end
            L_SHRA:  begin need_a = 1'b1; lres = bus.opa >> 1; end
            L_SHLA:  begin need_a = 1'b1; lres = bus.opa << 1; end
            L_SHRB:  begin need_b = 1'b1; lres = bus.opb >> 1; end
            L_SHLB:  begin need_b = 1'b1; lres = bus.opb << 1; end
            L_ROL:   begin need_a = 1'b1; need_b = 1'b1; lres = rot_l[2*WIDTH-1:WIDTH]; err_d = rot_hi; end
            L_ROR:   begin need_a = 1'b1; need_b = 1'b1; lres = rot_r[WIDTH-1:0]; err_d = rot_hi; end
            default: cmd_ok = 1'b0;
         endcase
         res_d = {2'b00, lres};
      end

      if (!cmd_ok || (need_a && !bus.inp_valid[0]) || (need_b && !bus.inp_valid[1])) begin
         res_d   = '0;
         oflow_d = 1'b0;
         cout_d  = 1'b0;
         g_d     = 1'b0;
         l_d     = 1'b0;
         e_d     = 1'b0;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         oflow_q <= 1'b0;
         cout_q  <= 1'b0;
         g_q     <= 1'b0;
         l_q     <= 1'b0;
         e_q     <= 1'b0;
         err_q   <= 1'b0;
      end else if (bus.ce) begin
         res_q   <= res_d;
         oflow_q <= oflow_d;
         cout_q  <= cout_d;
         g_q     <= g_d;
         l_q     <= l_d;
         e_q     <= e_d;
         err_q   <= err_d;
      end
   end

   assign bus.res   = res_q;
   assign bus.oflow = oflow_q;
   assign bus.cout  = cout_q;
   assign bus.g     = g_q;
   assign bus.l     = l_q;
   assign bus.e     = e_q;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_modport_alu.sv
// Scoreboard bench for modport_alu: the driver queues hand-computed results,
// a monitor pops and compares them one cycle after each driven edge.
module tb_modport_alu;
   localparam int unsigned W = 8;

   // Flag vector packing: {oflow, cout, g, l, e, err}
   localparam logic [5:0] F_NO = 6'b000000;
   localparam logic [5:0] F_OF = 6'b100000;
   localparam logic [5:0] F_CO = 6'b010000;
   localparam logic [5:0] F_G  = 6'b001000;
   localparam logic [5:0] F_L  = 6'b000100;
   localparam logic [5:0] F_E  = 6'b000010;
   localparam logic [5:0] F_ER = 6'b000001;

   typedef struct {
      string      name;
      logic [9:0] res;
      logic [5:0] fl;
   } exp_t;

   logic clk;
   logic reset;
   exp_t sbq[$];
   int   checks = 0;
   int   passed = 0;

   modport_alu_if #(.WIDTH(W)) bus ();

   modport_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (got running, required finished)");
      $fatal(1, "timeout");
   end

   always begin
      exp_t       x;
      logic [5:0] act_fl;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
         x      = sbq.pop_front();
         act_fl = {bus.oflow, bus.cout, bus.g, bus.l, bus.e, bus.err};
         checks++;
         if (bus.res === x.res && act_fl === x.fl)
            passed++;
         else
            $display("FAIL %s: res=%h flags=%b, required res=%h flags=%b",
                     x.name, bus.res, act_fl, x.res, x.fl);
      end
   end

   task automatic drive(input string nm, input logic rst, input logic c_e,
                        input logic md, input logic [3:0] cm,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] iv, input logic ci,
                        input logic [9:0] er, input logic [5:0] ef);
      @(negedge clk);
      reset         = rst;
      bus.ce        = c_e;
      bus.mode      = md;
      bus.cmd       = cm;
      bus.opa       = a;
      bus.opb       = b;
      bus.inp_valid = iv;
      bus.cin       = ci;
      sbq.push_back('{name: nm, res: er, fl: ef});
   endtask

   initial begin
      reset         = 1'b1;
      bus.ce        = 1'b0;
      bus.mode      = 1'b0;
      bus.cmd       = 4'd0;
      bus.opa       = '0;
      bus.opb       = '0;
      bus.inp_valid = 2'b00;
      bus.cin       = 1'b0;

      //     name          rst  ce   md   cmd    A      B      iv     cin   res      flags
      drive("reset",      1'b1, 1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 2'b11, 1'b0, 10'h000, F_NO);
      drive("add_ff_01",  1'b0, 1'b1, 1'b1, 4'd0, 8'hFF, 8'h01, 2'b11, 1'b0, 10'h100, F_CO);
      drive("reset_ce0",  1'b1, 1'b0, 1'b1, 4'd0, 8'hFF, 8'h01, 2'b11, 1'b0, 10'h000, F_NO);
      drive("subcin_eq",  1'b0, 1'b1, 1'b1, 4'd3, 8'h05, 8'h05, 2'b11, 1'b1, 10'h0FF, F_OF);
      drive("sub_10_03",  1'b0, 1'b1, 1'b1, 4'd1, 8'h10, 8'h03, 2'b11, 1'b0, 10'h00D, F_NO);
      drive("cmp_lt",     1'b0, 1'b1, 1'b1, 4'd8, 8'h20, 8'h30, 2'b11, 1'b0, 10'h000, F_L);
      drive("cmp_eq",     1'b0, 1'b1, 1'b1, 4'd8, 8'h7A, 8'h7A, 2'b11, 1'b0, 10'h000, F_E);
      drive("cmp_gt",     1'b0, 1'b1, 1'b1, 4'd8, 8'h30, 8'h20, 2'b11, 1'b0, 10'h000, F_G);
      drive("rol_81_1",   1'b0, 1'b1, 1'b0, 4'd12, 8'h81, 8'h01, 2'b11, 1'b0, 10'h003, F_NO);
      drive("rol_81_11",  1'b0, 1'b1, 1'b0, 4'd12, 8'h81, 8'h11, 2'b11, 1'b0, 10'h003, F_ER);
      drive("ror_81_1",   1'b0, 1'b1, 1'b0, 4'd13, 8'h81, 8'h01, 2'b11, 1'b0, 10'h0C0, F_NO);
      drive("incb_noB",   1'b0, 1'b1, 1'b1, 4'd6, 8'h10, 8'h10, 2'b01, 1'b0, 10'h000, F_ER);
      drive("nota_0f",    1'b0, 1'b1, 1'b0, 4'd6, 8'h0F, 8'hAA, 2'b01, 1'b0, 10'h0F0, F_NO);
      drive("arith_c12",  1'b0, 1'b1, 1'b1, 4'd12, 8'h01, 8'h01, 2'b11, 1'b0, 10'h000, F_ER);
      drive("logic_c14",  1'b0, 1'b1, 1'b0, 4'd14, 8'h01, 8'h01, 2'b11, 1'b0, 10'h000, F_ER);
      drive("iv_00",      1'b0, 1'b1, 1'b0, 4'd0, 8'hFF, 8'hFF, 2'b00, 1'b0, 10'h000, F_ER);
      drive("addcin_ff",  1'b0, 1'b1, 1'b1, 4'd2, 8'hFF, 8'h00, 2'b11, 1'b1, 10'h100, F_CO);
      drive("deca_0",     1'b0, 1'b1, 1'b1, 4'd5, 8'h00, 8'h33, 2'b01, 1'b0, 10'h0FF, F_OF);
      drive("decb_0",     1'b0, 1'b1, 1'b1, 4'd7, 8'h33, 8'h00, 2'b10, 1'b0, 10'h0FF, F_OF);
      drive("inca_ff",    1'b0, 1'b1, 1'b1, 4'd4, 8'hFF, 8'h00, 2'b01, 1'b0, 10'h100, F_CO);
      drive("shla_81",    1'b0, 1'b1, 1'b0, 4'd9, 8'h81, 8'h00, 2'b01, 1'b0, 10'h002, F_NO);
      drive("shrb_81",    1'b0, 1'b1, 1'b0, 4'd10, 8'h00, 8'h81, 2'b10, 1'b0, 10'h040, F_NO);
      drive("xnor_0f_33", 1'b0, 1'b1, 1'b0, 4'd5, 8'h0F, 8'h33, 2'b11, 1'b0, 10'h0C3, F_NO);
      drive("nand_f0_3c", 1'b0, 1'b1, 1'b0, 4'd1, 8'hF0, 8'h3C, 2'b11, 1'b0, 10'h0CF, F_NO);
      drive("add_1_1",    1'b0, 1'b1, 1'b1, 4'd0, 8'h01, 8'h01, 2'b11, 1'b1, 10'h002, F_NO);
      drive("hold_1",     1'b0, 1'b0, 1'b1, 4'd1, 8'h00, 8'h05, 2'b11, 1'b0, 10'h002, F_NO);
      drive("hold_2",     1'b0, 1'b0, 1'b1, 4'd8, 8'h09, 8'h09, 2'b11, 1'b0, 10'h002, F_NO);
      drive("hold_3",     1'b0, 1'b0, 1'b1, 4'd15, 8'hFF, 8'hFF, 2'b11, 1'b0, 10'h002, F_NO);
      drive("add_3_4",    1'b0, 1'b1, 1'b1, 4'd0, 8'h03, 8'h04, 2'b11, 1'b0, 10'h007, F_NO);
      drive("sub_lt",     1'b0, 1'b1, 1'b1, 4'd1, 8'h03, 8'h04, 2'b11, 1'b0, 10'h0FF, F_OF);
      drive("reset_mid",  1'b1, 1'b1, 1'b1, 4'd0, 8'hFF, 8'hFF, 2'b11, 1'b0, 10'h000, F_NO);
      drive("post_reset", 1'b0, 1'b1, 1'b1, 4'd0, 8'h10, 8'h20, 2'b11, 1'b0, 10'h030, F_NO);

      @(posedge clk);
      #3;
      checks++;
      if (sbq.size() == 0)
         passed++;
      else
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/modport_alu.md
# modport_alu

Registered, parameterizable two-operand ALU sitting behind the testbench's `alu_interface` driver/monitor clocking blocks. It supports arithmetic and logical command sets selected by `mode`, and per-operand valid qualification. It produces a widened result plus carry, overflow/borrow, compare and error flags one clock after the inputs are sampled.

## Interface
- `WIDTH`, default 8: operand width in bits.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `opa` input WIDTH: operand A.
- `opb` input WIDTH: operand B.
- `cmd` input 4: operation select, interpreted per `mode`.
- `ce` input 1: clock enable; outputs update only when 1.
- `inp_valid` input 2: bit0 = A valid, bit1 = B valid.
- `mode` input 1: 1 = arithmetic, 0 = logical.
- `cin` input 1: carry/borrow in for ADD_CIN/SUB_CIN.
- `res` output WIDTH+2: result, zero-extended.
- `oflow` output 1: borrow/underflow flag.
- `cout` output 1: carry-out flag.
- `g`, `l`, `e` output 1 each: compare flags for A>B, A<B and A==B.
- `err` output 1: error flag.

## Operation
Arithmetic commands (`mode`=1):
- 0 ADD: A+B.
- 1 SUB: A−B.
- 2 ADD_CIN: A+B+cin.
- 3 SUB_CIN: A−B−cin.
- 4 INC_A: A+1.
- 5 DEC_A: A−1.
- 6 INC_B: B+1.
- 7 DEC_B: B−1.
- 8 CMP.
- 9–15: invalid.

Logical commands (`mode`=0):
- 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
- 6 NOT_A, 7 NOT_B.
- 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
- 12 ROL_A_B: rotate A left by B.
- 13 ROR_A_B: rotate A right by B.
- 14–15: invalid.

Operand requirements:
- A only: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
- B only: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
- Every other valid command needs both A and B.
- If a required `inp_valid` bit is 0, or `inp_valid`=00, or `cmd` is invalid: `res`=0, all other flags 0, `err`=1.

Arithmetic width rules:
- Computed at WIDTH+1 bits, zero-extended into `res`.
- Add/increment: `cout` = bit WIDTH of the sum; `res[WIDTH]` equals `cout`.
- Subtract/decrement: `res` = difference mod 2^WIDTH in `res[WIDTH-1:0]`, upper bits 0.
- `oflow`=1 when a borrow occurs: SUB when A<B; SUB_CIN when A<B+cin; DEC_A when A=0; DEC_B when B=0.
- CMP: `res`=0; exactly one of `g`/`l`/`e` is 1.

Logical width rules:
- Result is WIDTH bits, upper `res` bits 0.
- Shifts fill with 0; the shifted-out bit is discarded.
- Rotates use amount `opb[$clog2(WIDTH)-1:0]`.
- Rotates set `err`=1 if any higher `opb` bit is 1; the rotated result is still driven.

Flag rules:
- Flags not defined for the executed op are 0: `g/l/e` outside CMP, `cout`/`oflow` outside arithmetic, `err` except as stated.
- `cin` is ignored except for ADD_CIN and SUB_CIN.

## Timing
- Fully registered outputs, latency 1 cycle.
- Inputs sampled at rising edge N (with `ce`=1) appear on outputs immediately after edge N and hold until the next enabled edge.
- `ce`=0 at an edge: all outputs hold their previous values; inputs are ignored.
- `reset`=1 at an edge: `res`, `oflow`, `cout`, `g`, `l`, `e` and `err` all become 0, regardless of `ce`.
- Reset has priority over `ce`; reset mid-stream discards the in-flight operation.
- First valid result appears one cycle after `reset` deasserts and the inputs are applied.
- No handshake or back-pressure: a new operation may be accepted every cycle.
- Combinational paths from inputs to outputs are forbidden.

## Test plan
- Reset, then ADD at WIDTH=8 with A=0xFF, B=0x01, `inp_valid`=11, `ce`=1 → next cycle `res`=0x100, `cout`=1, `err`=0; assert `reset` → `res`=0 and all flags 0.
- SUB_CIN with A=0x05, B=0x05, `cin`=1 → `res`=0x0FF, `oflow`=1. SUB with A=0x10, B=0x03 → `res`=0x00D, `oflow`=0.
- CMP with A=0x20, B=0x30 → `l`=1, `g`=0, `e`=0, `res`=0. CMP with A=B=0x7A → `e`=1.
- Logical ROL_A_B with A=0x81, B=0x01 → `res`=0x03, `err`=0. Same with B=0x11 → `res`=0x03, `err`=1.
- INC_B with `inp_valid`=01 → `err`=1, `res`=0. NOT_A with `inp_valid`=01, A=0x0F → `res`=0xF0. Arithmetic `cmd`=12 → `err`=1.
- Apply ADD with A=1, B=1 (`res`=2), then drive `ce`=0 with different inputs for 3 cycles → `res` stays 2. Re-assert `ce` → new result appears after one edge.
